// File: rtl/coherent_mem_ctrl.sv
// coherent_mem_ctrl: snoop-based coherent block memory controller for NCORES caches onto one RAM port.
module coherent_mem_ctrl #(
  parameter int NCORES = 4,
  parameter int BLKW = 2,
  parameter int CW = $clog2(NCORES),
  localparam int BW = BLKW > 1 ? $clog2(BLKW) : 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NCORES-1:0]        iREN,
  input  logic [NCORES-1:0][31:0]  iaddr,
  output logic [NCORES-1:0]        iwait,
  output logic [NCORES-1:0][31:0]  iload,
  input  logic [NCORES-1:0]        dREN,
  input  logic [NCORES-1:0]        dWEN,
  input  logic [NCORES-1:0]        ccwrite,
  input  logic [NCORES-1:0][31:0]  daddr,
  input  logic [NCORES-1:0][31:0]  dstore,
  output logic [NCORES-1:0]        dwait,
  output logic [NCORES-1:0][31:0]  dload,
  output logic [NCORES-1:0]        ccwait,
  output logic [NCORES-1:0][31:0]  ccsnoopaddr,
  output logic [NCORES-1:0]        ccinv,
  input  logic [NCORES-1:0]        cctrans,
  output logic [BW-1:0]            ccbeat,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [31:0]              ramaddr,
  output logic [31:0]              ramstore,
  input  logic [31:0]              ramload,
  input  logic [1:0]               ramstate
);
  localparam logic [2:0] IDLE = 3'd0, WB = 3'd1, SEND = 3'd2, SNOOP = 3'd3,
                         C2C = 3'd4, MEMRD = 3'd5, FETCH = 3'd6;

  logic [2:0] state_q, state_d;
  logic [CW-1:0] owner_q, owner_d, rr_q, rr_d, supplier_q, supplier_d, nxt_owner;
  logic [BW-1:0] beat_q, beat_d;
  logic [31:0] base_q, base_d, beat_addr;
  logic inv_q, inv_d, acc, last;
  logic [CW:0] wi, ri, ii, sp;

  // Returns {found, index}: first requester at offset >= first from start, wrapping mod NCORES.
  function automatic logic [CW:0] pick(input logic [NCORES-1:0] req, input logic [CW-1:0] start,
                                       input int first);
    logic [CW:0] r;
    r = '0;
    for (int i = NCORES - 1; i >= first; i--) begin
      int idx;
      idx = (int'(start) + i) % NCORES;
      if (req[idx]) r = {1'b1, CW'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    acc = ramstate == 2'b10;
    last = beat_q == BW'(BLKW - 1);
    nxt_owner = owner_q == CW'(NCORES - 1) ? '0 : owner_q + 1'b1;
    beat_addr = base_q + (32'(beat_q) << 2);
    wi = pick(dWEN, rr_q, 0);
    ri = pick(dREN, rr_q, 0);
    ii = pick(iREN, rr_q, 0);
    sp = pick(cctrans, owner_q, 1);
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    supplier_d = supplier_q;
    beat_d = beat_q;
    base_d = base_q;
    inv_d = inv_q;
    case (state_q)
      IDLE: begin
        if (wi[CW]) begin
          state_d = WB;
          owner_d = wi[CW-1:0];
          base_d = daddr[wi[CW-1:0]];
        end else if (ri[CW]) begin
          state_d = SEND;
          owner_d = ri[CW-1:0];
          base_d = daddr[ri[CW-1:0]];
          inv_d = ccwrite[ri[CW-1:0]];
        end else if (ii[CW]) begin
          state_d = FETCH;
          owner_d = ii[CW-1:0];
        end
      end
      WB, C2C, MEMRD: begin
        if (acc) begin
          beat_d = last ? '0 : beat_q + 1'b1;
          state_d = last ? IDLE : state_q;
          rr_d = last ? nxt_owner : rr_q;
        end
      end
      SEND: state_d = SNOOP;
      SNOOP: begin
        inv_d = 1'b0;
        supplier_d = sp[CW-1:0];
        state_d = sp[CW] ? C2C : MEMRD;
      end
      FETCH: begin
        if (acc) begin
          state_d = IDLE;
          rr_d = nxt_owner;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    ccwait = '0;
    ccsnoopaddr = '0;
    ccinv = '0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    ccbeat = beat_q;
    case (state_q)
      WB: begin
        ramWEN = 1'b1;
        ramaddr = beat_addr;
        ramstore = dstore[owner_q];
        if (acc) dwait[owner_q] = 1'b0;
      end
      SEND, SNOOP: begin
        for (int k = 0; k < NCORES; k++) begin
          if (CW'(k) != owner_q) begin
            ccwait[k] = 1'b1;
            ccsnoopaddr[k] = base_q;
            ccinv[k] = inv_q;
          end
        end
      end
      C2C: begin
        ccwait[supplier_q] = 1'b1;
        ramWEN = 1'b1;
        ramaddr = beat_addr;
        ramstore = dstore[supplier_q];
        dload[owner_q] = dstore[supplier_q];
        if (acc) begin
          dwait[owner_q] = 1'b0;
          dwait[supplier_q] = 1'b0;
        end
      end
      MEMRD: begin
        ramREN = 1'b1;
        ramaddr = beat_addr;
        if (acc) begin
          dload[owner_q] = ramload;
          dwait[owner_q] = 1'b0;
        end
      end
      FETCH: begin
        ramREN = 1'b1;
        ramaddr = iaddr[owner_q];
        if (acc) begin
          iload[owner_q] = ramload;
          iwait[owner_q] = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      supplier_q <= '0;
      beat_q <= '0;
      base_q <= '0;
      inv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      supplier_q <= supplier_d;
      beat_q <= beat_d;
      base_q <= base_d;
      inv_q <= inv_d;
    end
  end
endmodule

// File: tb/tb_coherent_mem_ctrl.sv
// tb_coherent_mem_ctrl: scoreboard bench for a 4-core and a 3-core controller with a latency-programmable RAM model.
module tb_coherent_mem_ctrl;
  localparam int N = 4;
  localparam int M = 3;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] iREN, dREN, dWEN, ccwrite, cctrans, iwait, dwait, ccwait, ccinv;
  logic [N-1:0][31:0] iaddr, daddr, dstore, iload, dload, ccsnoopaddr;
  logic [0:0] ccbeat;
  logic ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0] ramstate;

  logic [M-1:0] iREN3, dREN3, iwait3, dwait3, ccwait3, ccinv3;
  logic [M-1:0][31:0] iaddr3, daddr3, iload3, dload3, ccsnoopaddr3;
  logic [0:0] ccbeat3;
  logic ram3REN, ram3WEN;
  logic [31:0] ram3addr, ram3store, ram3load;
  logic [1:0] ram3state;

  int lat = 0;
  bit err_en = 1'b0;
  int cnt = 0;

  // RAM returns address with the top half inverted; latency counts BUSY (or ERROR at count 1) cycles before ACCESS
  always_comb begin
    for (int k = 0; k < N; k++) dstore[k] = 32'hD000_0000 + 32'(k << 8) + 32'(ccbeat);
    ramload = ramaddr ^ 32'hFFFF_0000;
    ramstate = !(ramREN | ramWEN) ? 2'b00 : cnt < lat ? ((err_en && cnt == 1) ? 2'b11 : 2'b01) : 2'b10;
    ram3load = ram3addr ^ 32'hFFFF_0000;
    ram3state = (ram3REN | ram3WEN) ? 2'b10 : 2'b00;
  end

  always @(posedge clk) cnt <= (!(ramREN | ramWEN) || ramstate == 2'b10) ? 0 : cnt + 1;

  coherent_mem_ctrl #(.NCORES(N), .BLKW(2)) u (
    .CLK(clk), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccsnoopaddr(ccsnoopaddr), .ccinv(ccinv),
    .cctrans(cctrans), .ccbeat(ccbeat), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate));

  coherent_mem_ctrl #(.NCORES(M), .BLKW(2)) u3 (
    .CLK(clk), .nRST(nRST), .iREN(iREN3), .iaddr(iaddr3), .iwait(iwait3), .iload(iload3),
    .dREN(dREN3), .dWEN('0), .ccwrite('0), .daddr(daddr3), .dstore('0),
    .dwait(dwait3), .dload(dload3), .ccwait(ccwait3), .ccsnoopaddr(ccsnoopaddr3), .ccinv(ccinv3),
    .cctrans('0), .ccbeat(ccbeat3), .ramREN(ram3REN), .ramWEN(ram3WEN), .ramaddr(ram3addr),
    .ramstore(ram3store), .ramload(ram3load), .ramstate(ram3state));

  typedef struct {bit d; int core; logic [31:0] data;} ev_t;
  ev_t eq[$];
  ev_t eq3[$];
  logic [63:0] wq[$];
  int checks = 0;
  int fails = 0;

  function automatic void push_ev(input int which, input bit d, input int core, input logic [31:0] data);
    ev_t e;
    e.d = d;
    e.core = core;
    e.data = data;
    if (which == 3) eq3.push_back(e);
    else eq.push_back(e);
  endfunction

  function automatic void got(input int which, input bit d, input int core, input logic [31:0] data);
    ev_t e;
    checks++;
    if ((which == 3 ? eq3.size() : eq.size()) == 0) begin
      fails++;
      $display("FAIL ev_u%0d: got %s core %0d data %h, required no event", which, d ? "dwait" : "iwait", core, data);
      return;
    end
    if (which == 3) e = eq3.pop_front();
    else e = eq.pop_front();
    if (e.d !== d || e.core != core || e.data !== data) begin
      fails++;
      $display("FAIL ev_u%0d: got %s core %0d data %h, required %s core %0d data %h", which,
               d ? "dwait" : "iwait", core, data, e.d ? "dwait" : "iwait", e.core, e.data);
    end
  endfunction

  always @(negedge clk) begin
    if (nRST) begin
      for (int k = 0; k < N; k++) begin
        if (!iwait[k]) got(4, 1'b0, k, iload[k]);
        if (!dwait[k]) got(4, 1'b1, k, dload[k]);
      end
      for (int k = 0; k < M; k++) begin
        if (!iwait3[k]) got(3, 1'b0, k, iload3[k]);
        if (!dwait3[k]) got(3, 1'b1, k, dload3[k]);
      end
      if (ramWEN && ramstate == 2'b10) begin
        logic [63:0] w;
        checks++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL ramwrite: got addr %h data %h, required no write", ramaddr, ramstore);
        end else begin
          w = wq.pop_front();
          if ({ramaddr, ramstore} !== w) begin
            fails++;
            $display("FAIL ramwrite: got addr %h data %h, required addr %h data %h", ramaddr, ramstore, w[63:32], w[31:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_left(input int which, input int n, input int budget, output int c);
    c = 0;
    while ((which == 3 ? eq3.size() : eq.size()) > n && c < budget) begin
      @(negedge clk);
      #2;
      c++;
    end
    if ((which == 3 ? eq3.size() : eq.size()) > n) begin
      checks++;
      fails++;
      $display("FAIL timeout_u%0d: %0d events outstanding, required %0d", which,
               which == 3 ? eq3.size() : eq.size(), n);
    end
  endtask

  initial begin
    int c;
    iREN = '1; dREN = '1; dWEN = '1; ccwrite = '1; cctrans = '1;
    for (int k = 0; k < N; k++) begin
      iaddr[k] = 32'h40 + 32'(k * 16);
      daddr[k] = '0;
    end
    iREN3 = '0; dREN3 = '0; iaddr3 = '0; daddr3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_iwait", 64'(iwait), 64'hF);
    chk("rst_dwait", 64'(dwait), 64'hF);
    chk("rst_ram", {ramREN, ramWEN}, 2'b00);
    chk("rst_ccwait", 64'(ccwait), 64'h0);
    chk("rst_ccinv", 64'(ccinv), 64'h0);
    dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    for (int r = 0; r < 5; r++) push_ev(4, 1'b0, r % N, 32'hFFFF_0040 + 32'((r % N) * 16));
    @(negedge clk);
    nRST = 1'b1;
    #1;
    chk("release_strobe", {ramREN, ramWEN}, 2'b00);
    wait_left(4, 0, 60, c);
    iREN = '0;

    @(negedge clk);
    iREN[2] = 1'b1; iaddr[2] = 32'h80;
    dWEN[3] = 1'b1; daddr[3] = 32'h300;
    push_ev(4, 1'b1, 3, 32'h0);
    push_ev(4, 1'b1, 3, 32'h0);
    push_ev(4, 1'b0, 2, 32'hFFFF_0080);
    wq.push_back({32'h300, 32'hD000_0300});
    wq.push_back({32'h304, 32'hD000_0301});
    wait_left(4, 1, 30, c);
    dWEN[3] = 1'b0;
    wait_left(4, 0, 30, c);
    iREN[2] = 1'b0;

    @(negedge clk);
    dREN[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h100; cctrans[3] = 1'b1;
    push_ev(4, 1'b1, 1, 32'hD000_0300);
    push_ev(4, 1'b1, 3, 32'h0);
    push_ev(4, 1'b1, 1, 32'hD000_0301);
    push_ev(4, 1'b1, 3, 32'h0);
    wq.push_back({32'h100, 32'hD000_0300});
    wq.push_back({32'h104, 32'hD000_0301});
    c = 0;
    while (!ccwait[0] && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("send_ccwait", 64'(ccwait), 64'hD);
    chk("send_ccinv", 64'(ccinv), 64'hD);
    chk("send_snoopaddr", 64'(ccsnoopaddr[2]), 64'h100);
    @(negedge clk);
    chk("snoop_ccinv", 64'(ccinv), 64'hD);
    wait_left(4, 0, 30, c);
    dREN[1] = 1'b0; ccwrite[1] = 1'b0; cctrans[3] = 1'b0;

    @(negedge clk);
    lat = 3; err_en = 1'b1;
    dREN[1] = 1'b1; daddr[1] = 32'h200;
    push_ev(4, 1'b1, 1, 32'hFFFF_0200);
    push_ev(4, 1'b1, 1, 32'hFFFF_0204);
    wait_left(4, 0, 40, c);
    dREN[1] = 1'b0;
    chk("fill_cycles", 64'(c), 64'd10);
    lat = 0; err_en = 1'b0;

    @(negedge clk);
    iREN3[1] = 1'b1; iaddr3[1] = 32'h44;
    push_ev(3, 1'b0, 1, 32'hFFFF_0044);
    wait_left(3, 0, 20, c);
    iREN3[1] = 1'b0;
    @(negedge clk);
    dREN3[0] = 1'b1; daddr3[0] = 32'h400;
    dREN3[2] = 1'b1; daddr3[2] = 32'h500;
    push_ev(3, 1'b1, 2, 32'hFFFF_0500);
    push_ev(3, 1'b1, 2, 32'hFFFF_0504);
    push_ev(3, 1'b1, 0, 32'hFFFF_0400);
    push_ev(3, 1'b1, 0, 32'hFFFF_0404);
    wait_left(3, 2, 30, c);
    dREN3[2] = 1'b0;
    wait_left(3, 0, 30, c);
    dREN3[0] = 1'b0;

    repeat (4) @(negedge clk);
    chk("eq_drained", 64'(eq.size()), 64'd0);
    chk("eq3_drained", 64'(eq3.size()), 64'd0);
    chk("wq_drained", 64'(wq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/coherent_mem_ctrl.md
# coherent_mem_ctrl

N-core, block-granular memory controller with snoop-based coherence: arbitrates instruction fetches, data write-backs and coherent data fills from `NCORES` private caches onto a single-ported RAM. On a data fill it broadcasts a snoop to every other core and sources the block from a peer cache (cache-to-cache, with simultaneous RAM update) when a peer claims it, otherwise from RAM. It sits between the per-core caches and the RAM model. It replaces the fixed two-core, two-word controller with configurable core count and block length, plus round-robin fairness across all cores.

## Interface
- `NCORES`, 4, number of cores (≥2).
- `BLKW`, 2, words per cache block (power of two, ≥1).
- `CW`, `$clog2(NCORES)`, core-index width (derived).
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `iREN` in NCORES: per-core instruction read request.
- `iaddr` in NCORES×32: per-core fetch address.
- `iwait` out NCORES: 0 = fetch word valid this cycle.
- `iload` out NCORES×32: fetch data.
- `dREN`, `dWEN` in NCORES: per-core data block read / write-back request.
- `ccwrite` in NCORES: fill is for write (peers must invalidate).
- `daddr` in NCORES×32: block base address (word aligned, block aligned).
- `dstore` in NCORES×32: write-back / peer-supplied word, current beat.
- `dwait` out NCORES: 0 = current beat completes this cycle.
- `dload` out NCORES×32: fill data.
- `ccwait` out NCORES: 1 = core is being snooped / supplying; its cache must stall.
- `ccsnoopaddr` out NCORES×32: snoop block address.
- `ccinv` out NCORES: invalidate snooped block.
- `cctrans` in NCORES: snooped core holds block modified and will supply it.
- `ccbeat` out log2(BLKW) (min 1): current beat index; suppliers drive `dstore` for that word.
- `ramREN`, `ramWEN` out 1; `ramaddr` out 32; `ramstore` out 32; `ramload` in 32.
- `ramstate` in 2: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.

## Operation
- States: IDLE, WB, SEND, SNOOP, C2C, MEMRD, FETCH. Registered: state, `owner` (CW), `rr` (CW), `supplier` (CW), `beat`, `base` (32), `inv`.
- IDLE arbitration by class: any `dWEN` > any `dREN` > any `iREN`. Within a class, the first requesting core at or after `rr` (wrapping modulo NCORES) wins and becomes `owner`.
- `dWEN` win: go to WB, latch `base=daddr[owner]`, beat=0.
- `dREN` win: go to SEND, latch base and `inv=ccwrite[owner]`.
- `iREN` win: go to FETCH.
- WB: `ramWEN=1`, `ramaddr=base+4*beat`, `ramstore=dstore[owner]`. On ACCESS, `dwait[owner]=0` and beat++. After beat BLKW-1 completes, go to IDLE.
- SEND (1 cycle) and SNOOP (1 cycle): for every core k≠owner, `ccwait[k]=1`, `ccsnoopaddr[k]=base`, `ccinv[k]=inv`. In SNOOP, `supplier` = first k≠owner with `cctrans[k]`, searched from owner+1 wrapping. If a supplier is found go to C2C, else go to MEMRD. `inv` clears on leaving SNOOP.
- C2C: `ccwait[supplier]=1`, `ramWEN=1`, `ramaddr=base+4*beat`, `ramstore=dstore[supplier]`, `dload[owner]=dstore[supplier]`. On ACCESS, `dwait[owner]=0`, `dwait[supplier]=0`, beat++. After the last beat, go to IDLE.
- MEMRD: `ramREN=1`, `ramaddr=base+4*beat`. On ACCESS, `dload[owner]=ramload`, `dwait[owner]=0`, beat++. After the last beat, go to IDLE.
- FETCH: `ramREN=1`, `ramaddr=iaddr[owner]`. On ACCESS, `iload[owner]=ramload`, `iwait[owner]=0`, then go to IDLE.
- Every completion back to IDLE sets `rr=owner+1` (mod NCORES, including non-power-of-two wrap).
- ERROR and BUSY are both treated as not-ready: hold state and beat, no wait deasserted.
- Defaults, when not driven above: `iwait`/`dwait` all 1; every other output 0. `ccbeat=beat`.

## Timing
- Reset: state IDLE, `rr=0`, `owner=0`, `beat=0`, `base=0`, `inv=0`. All waits 1, all other outputs 0.
- Reset asserted mid-transaction aborts immediately. No RAM strobe is asserted in the cycle after release.
- IDLE decision takes 1 cycle. Minimum fill latency with a 1-cycle RAM is 2 (SEND, SNOOP) + BLKW cycles after the IDLE cycle.
- RAM outputs are combinational from registered state. Beat advances on the edge after ACCESS.
- A requester must hold its request and `daddr` until its final `dwait`=0. The controller reads `dstore` combinationally each beat.
- Requests arriving during a transaction wait. A request that drops while not owner is simply skipped.

## Test plan
- Reset: hold nRST=0 with all requests high → all waits 1, `ramREN`=`ramWEN`=0, `ccwait`=0. Release → first grant is core 0.
- Fairness, NCORES=4: all `iREN` held, 1-cycle RAM → `iwait` pulses in order core 0,1,2,3,0. Each pulse returns `ramload` at `iaddr[k]`.
- Priority: core 2 `iREN` and core 3 `dWEN` in the same cycle → WB for core 3 first. BLKW=2 writes go to base and base+4, then core 2's fetch.
- Cache-to-cache, NCORES=4: core 1 `dREN`+`ccwrite` at 0x100, core 3 asserts `cctrans` in SNOOP → `ccinv[0,2,3]`=1 during snoop. `dload[1]` equals `dstore[3]` per beat, and RAM is written at 0x100 and 0x104.
- Memory fill: no `cctrans` → MEMRD, 2 beats. A 3-cycle BUSY before each ACCESS stretches `dwait[1]` accordingly, and the beat does not advance on BUSY or ERROR.
- Wrap: NCORES=3, rr=2, cores 0 and 2 `dREN` → core 2 served first, then rr=0 → core 0.
